// File: rtl/ge_p3_to_cached.sv
// Converts an extended point (X,Y,Z,T) to cached form (Y+X, Y-X, Z, 2d*T) using borrowed
// field adder, subtractor and multiplier. Optional error gate: define GE_CACHED_ERR_GATE_EN.
module ge_p3_to_cached (
  input  logic         clk,
  input  logic         rst,
`ifdef GE_CACHED_ERR_GATE_EN
  input  logic         error_in,
  output logic         error_out,
`endif
  input  logic         valid,
  input  logic [319:0] p_x,
  input  logic [319:0] p_y,
  input  logic [319:0] p_z,
  input  logic [319:0] p_t,
  output logic         done,
  output logic [319:0] c_yplusx,
  output logic [319:0] c_yminusx,
  output logic [319:0] c_z,
  output logic [319:0] c_t2d,
  output logic [319:0] mul_op_a,
  output logic [319:0] mul_op_b,
  output logic         mul_valid,
  input  logic [319:0] mul_res,
  input  logic         mul_done,
  output logic [319:0] add_op_a,
  output logic [319:0] add_op_b,
  input  logic [319:0] add_res,
  output logic [319:0] sub_op_a,
  output logic [319:0] sub_op_b,
  input  logic [319:0] sub_res
);

  // 2d in ten signed 32-bit limbs, limb 9 in the top word
  localparam logic [319:0] TWO_D = {
    32'sd9444199,  32'sd29715968, -32'sd6495438,  -32'sd12551817, 32'sd15978800,
    32'sd229458,   32'sd13898782, -32'sd30745221, -32'sd5839606,  -32'sd21827239
  };

  typedef enum logic [2:0] {
    S_IDLE, S_ADDSUB, S_MUL_REQ, S_MUL_WAIT, S_FIN
  } state_t;

  state_t       state_q, state_d;
  logic [319:0] x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d;
  logic [319:0] yplusx_q, yplusx_d, yminusx_q, yminusx_d;
  logic [319:0] cz_q, cz_d, t2d_q, t2d_d;
  logic         done_q, done_d;
`ifdef GE_CACHED_ERR_GATE_EN
  logic         err_q, err_d;
  logic         error_out_q, error_out_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      t_q       <= '0;
      yplusx_q  <= '0;
      yminusx_q <= '0;
      cz_q      <= '0;
      t2d_q     <= '0;
      done_q    <= 1'b0;
`ifdef GE_CACHED_ERR_GATE_EN
      err_q       <= 1'b0;
      error_out_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      t_q       <= t_d;
      yplusx_q  <= yplusx_d;
      yminusx_q <= yminusx_d;
      cz_q      <= cz_d;
      t2d_q     <= t2d_d;
      done_q    <= done_d;
`ifdef GE_CACHED_ERR_GATE_EN
      err_q       <= err_d;
      error_out_q <= error_out_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    t_d       = t_q;
    yplusx_d  = yplusx_q;
    yminusx_d = yminusx_q;
    cz_d      = cz_q;
    t2d_d     = t2d_q;
    done_d    = done_q;
`ifdef GE_CACHED_ERR_GATE_EN
    err_d       = err_q;
    error_out_d = error_out_q;
`endif
    // Operand ports idle at zero so the arbiter can OR requests together
    add_op_a  = '0;
    add_op_b  = '0;
    sub_op_a  = '0;
    sub_op_b  = '0;
    mul_op_a  = '0;
    mul_op_b  = '0;
    mul_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          x_d     = p_x;
          y_d     = p_y;
          z_d     = p_z;
          t_d     = p_t;
          done_d  = 1'b0;
          state_d = S_ADDSUB;
`ifdef GE_CACHED_ERR_GATE_EN
          err_d = error_in;
          if (error_in) state_d = S_FIN;
`endif
        end
      end
      S_ADDSUB: begin
        add_op_a  = y_q;
        add_op_b  = x_q;
        sub_op_a  = y_q;
        sub_op_b  = x_q;
        yplusx_d  = add_res;
        yminusx_d = sub_res;
        cz_d      = z_q;
        state_d   = S_MUL_REQ;
      end
      S_MUL_REQ: begin
        mul_op_a  = t_q;
        mul_op_b  = TWO_D;
        mul_valid = 1'b1;
        state_d   = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        mul_op_a = t_q;
        mul_op_b = TWO_D;
        if (mul_done) begin
          t2d_d   = mul_res;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef GE_CACHED_ERR_GATE_EN
        error_out_d = err_q;
        if (err_q) begin
          yplusx_d  = '0;
          yminusx_d = '0;
          cz_d      = '0;
          t2d_d     = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done      = done_q;
  assign c_yplusx  = yplusx_q;
  assign c_yminusx = yminusx_q;
  assign c_z       = cz_q;
  assign c_t2d     = t2d_q;
`ifdef GE_CACHED_ERR_GATE_EN
  assign error_out = error_out_q;
`endif

endmodule

// File: doc/ge_p3_to_cached.md
Name: ge_p3_to_cached

Overview:
- Consumes the extended point A (X, Y, Z, T) from the point-decompression stage and produces its cached form for the double-scalar-multiplication precompute table.
- Cached form: YplusX = Y+X, YminusX = Y−X, Z = Z, T2d = T·2d.
- Like its upstream neighbour, it owns no arithmetic. It borrows the shared multiplier through a valid/done handshake and the combinational field adder and subtractor through operand/result ports.
- Field elements are 320 bits: 10 signed 32-bit limbs, limb 0 in bits [31:0].

Parameters:
- None. The constant 2d is fixed.
- 2d limbs 0..9, decimal, two's complement: -21827239, -5839606, -30745221, 13898782, 229458, 15978800, -12551817, -6495438, 29715968, 9444199.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- valid  in  1  start pulse; p_* sampled on the same edge
- p_x, p_y, p_z, p_t  in  320 each  input point
- done  out  1  result valid (level)
- c_yplusx, c_yminusx, c_z, c_t2d  out  320 each  cached point
- mul_op_a, mul_op_b  out  320 each  multiplier operands
- mul_valid  out  1  multiplier start
- mul_res  in  320  multiplier result
- mul_done  in  1  multiplier result valid
- add_op_a, add_op_b  out  320 each  adder operands
- add_res  in  320  add_op_a + add_op_b, combinational
- sub_op_a, sub_op_b  out  320 each  subtractor operands
- sub_res  in  320  sub_op_a − sub_op_b, combinational

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. All outputs 0, including done, mul_valid and every operand port. Internal point registers cleared.
- FSM states: IDLE, ADDSUB, MUL_REQ, MUL_WAIT, FIN.
- IDLE:
  - valid=1 → latch p_x..p_t into internal registers, clear done, go to ADDSUB.
  - valid=0 → stay; done holds its value.
- ADDSUB:
  - Drive add_op_a=Y, add_op_b=X, sub_op_a=Y, sub_op_b=X from the latched registers.
  - On the edge, capture c_yplusx<=add_res, c_yminusx<=sub_res, c_z<=Z. Go to MUL_REQ.
- MUL_REQ:
  - mul_op_a=T, mul_op_b=2d; mul_valid=1 for exactly this one cycle. Go to MUL_WAIT.
- MUL_WAIT:
  - Operands held stable, mul_valid=0.
  - On the first edge with mul_done=1, capture c_t2d<=mul_res and go to FIN.
  - No timeout.
- FIN: done<=1, go to IDLE.
- Operand ports: outside the states that use them, drive 0, so the arbiter can OR-combine resource requests.
- Latency: accept edge k, mul_valid high during cycle k+2, done high one cycle after the edge that samples mul_done.
  - With a 1-cycle multiplier (mul_done in cycle k+3), done rises after edge k+4.
- done is a level: high from FIN until the next accepted valid or reset. Outputs stay stable while done=1.
- valid outside IDLE is ignored; no queueing, no effect on the in-flight operation.
- valid in the same cycle FIN→IDLE: not accepted (FSM is in FIN). It is accepted one cycle later if still high.
- mul_done outside MUL_WAIT is ignored.
- No width growth: add_res, sub_res and mul_res are stored verbatim. Limb carry is the resource's responsibility.

Optional Feature:
- Macro GE_CACHED_ERR_GATE_EN.
- When defined:
  - Extra input error_in (1 bit) sampled with valid; extra output error_out (1 bit), reset 0.
  - valid=1 with error_in=1: skip ADDSUB/MUL, go straight to FIN. All four c_* outputs are set to 0, error_out=1. No mul_valid is issued and the adder and subtractor operands stay 0.
  - valid=1 with error_in=0: normal flow, error_out=0.
  - error_out updates only at FIN.
- When undefined:
  - Ports error_in and error_out do not exist.
  - Every accepted valid takes the full path.

Test Plan:
- Reset mid-operation: assert rst while in MUL_WAIT → same cycle all outputs 0, mul_valid 0, done 0. Next valid after release completes normally.
- Identity point X=0, Y=1, Z=1, T=0 with a 1-cycle-latency multiplier model:
  - Expect c_yplusx=1, c_yminusx=1, c_z=1, c_t2d=0.
  - mul_valid high exactly one cycle, in cycle k+2; done rises after edge k+4.
- T=1, X=Y=Z=0 → c_t2d equals the multiplier model's result for (2d, 1), i.e. the 2d limbs after carry. c_yplusx=c_yminusx=c_z=0.
- Multiplier stall: mul_done delayed 20 cycles → mul_op_a/mul_op_b stable throughout, done stays 0 until after mul_done. Spurious mul_done in IDLE is ignored.
- Busy rejection: second valid with different inputs asserted during MUL_WAIT → results correspond to the first point only. Done stays high afterwards until a new valid in IDLE clears it.
- With GE_CACHED_ERR_GATE_EN, valid with error_in=1 → done after 2 edges, error_out=1, all c_* = 0, mul_valid never asserted.
